// File: rtl/pulse_swallow_ctrl.sv
// pulse_swallow_ctrl
//   Program/swallow counter of a dual-modulus (P / P+1) fractional-N divider.
//   Clocked by the prescaler output. Each divided period lasts Pc prescaler
//   cycles: mc is held high (divide by P+1) for the first S of those cycles and
//   low (divide by P) for the rest, so one period spans N = P*Pc + S VCO cycles.
//   The ratio is sampled once per period, on the load edge; a ratio that
//   cannot be realised (Pc == 0 or S > Pc) is rejected and the previous one is
//   reused.
// Ports
//   clk       prescaler output clock
//   rst_n     asynchronous active-low reset
//   en        run enable; low parks the counter in IDLE
//   ratio_i   requested division ratio N (sampled on load edges only)
//   mc        modulus control, 1 = P+1, 0 = P
//   div_out   1-cycle pulse on the first cycle of each divided period
//   div_tgl   toggles on every div_out pulse
//   load_o    1-cycle pulse: ratio_i accepted for this period
//   ratio_err 1-cycle pulse: ratio_i rejected, previous ratio reused
module pulse_swallow_ctrl #(
  parameter int N_W       = 8,
  parameter int P_LOG2    = 2,
  parameter int RST_RATIO = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N_W-1:0] ratio_i,
  output logic           mc,
  output logic           div_out,
  output logic           div_tgl,
  output logic           load_o,
  output logic           ratio_err
);

  localparam int PC_W = N_W - P_LOG2;
  localparam logic [PC_W-1:0]   PC_ONE = PC_W'(1);
  localparam logic [P_LOG2-1:0] S_ONE  = P_LOG2'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [PC_W-1:0]   p_cnt;
  logic [P_LOG2-1:0] s_cnt;
  logic [N_W-1:0]    active;

  logic [PC_W-1:0]   pc_in;
  logic [P_LOG2-1:0] s_in;
  logic              valid;
  logic [N_W-1:0]    new_ratio;
  logic              load;

  assign pc_in     = ratio_i[N_W-1:P_LOG2];
  assign s_in      = ratio_i[P_LOG2-1:0];
  // Pc >= S guarantees the swallow phase fits inside the period.
  assign valid     = (pc_in != '0) && (pc_in >= PC_W'(s_in));
  assign new_ratio = valid ? ratio_i : active;
  assign load      = en && ((state == IDLE) || (p_cnt == '0));

  // Swallow counter nonzero <=> still in the P+1 phase of the period.
  assign mc = (s_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p_cnt     <= '0;
      s_cnt     <= '0;
      active    <= N_W'(RST_RATIO);
      div_out   <= 1'b0;
      div_tgl   <= 1'b0;
      load_o    <= 1'b0;
      ratio_err <= 1'b0;
    end else if (!en) begin
      // div_tgl and the active ratio survive a pause.
      state     <= IDLE;
      p_cnt     <= '0;
      s_cnt     <= '0;
      div_out   <= 1'b0;
      load_o    <= 1'b0;
      ratio_err <= 1'b0;
    end else if (load) begin
      state     <= RUN;
      active    <= new_ratio;
      p_cnt     <= new_ratio[N_W-1:P_LOG2] - PC_ONE;
      s_cnt     <= new_ratio[P_LOG2-1:0];
      div_out   <= 1'b1;
      div_tgl   <= ~div_tgl;
      load_o    <= valid;
      ratio_err <= ~valid;
    end else begin
      p_cnt     <= p_cnt - PC_ONE;
      if (s_cnt != '0) s_cnt <= s_cnt - S_ONE;
      div_out   <= 1'b0;
      load_o    <= 1'b0;
      ratio_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Directed bench for pulse_swallow_ctrl (N_W=8, P_LOG2=2, RST_RATIO=23).
// Outputs are observed 1 time unit after each rising edge as the packed vector
// {mc, div_out, div_tgl, load_o, ratio_err}.
module tb_pulse_swallow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] ratio_i = 8'd23;
  logic       mc, div_out, div_tgl, load_o, ratio_err;
  logic [4:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_tgl = 1'b0;

  assign obs = {mc, div_out, div_tgl, load_o, ratio_err};

  pulse_swallow_ctrl #(.N_W(8), .P_LOG2(2), .RST_RATIO(23)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ratio_i(ratio_i),
    .mc(mc), .div_out(div_out), .div_tgl(div_tgl),
    .load_o(load_o), .ratio_err(ratio_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_tgl = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    #3;
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset obs got %b exp %b", obs, 5'b00000);
    end
    do_reset();
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_idle obs got %b exp %b", obs, 5'b00000);
    end
  endtask

  // N=23: Pc=5, S=3 -> period 5, mc 1,1,1,0,0.
  task automatic test_steady23();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd23;
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k % 5 == 0) exp_tgl = ~exp_tgl;
      e = {(k % 5) < 3, k % 5 == 0, exp_tgl, k % 5 == 0, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL steady23 k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  // N=10 (Pc=2,S=2): period 2, mc always 1; then N=12 (Pc=3,S=0): period 3, mc 0.
  task automatic test_edge_ratios();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd10;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) exp_tgl = ~exp_tgl;
      e = {1'b1, k % 2 == 0, exp_tgl, k % 2 == 0, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ratio10 k=%0d got %b exp %b", k, obs, e);
      end
    end
    ratio_i = 8'd12;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k % 3 == 0) exp_tgl = ~exp_tgl;
      e = {1'b0, k % 3 == 0, exp_tgl, k % 3 == 0, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ratio12 k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  // N=5 (Pc=1,S=1): load every cycle, div_out stuck high, div_tgl toggles each cycle.
  task automatic test_pc_one();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd5;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_tgl = ~exp_tgl;
      e = {1'b1, 1'b1, exp_tgl, 1'b1, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pc_one k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  // 23 -> 11 (invalid) mid-period: rejected at next load, 23 reused; 23 restored later.
  task automatic test_invalid();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd23;
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k % 5 == 0) exp_tgl = ~exp_tgl;
      e = {(k % 5) < 3, k % 5 == 0, exp_tgl, (k % 5 == 0) && (k != 5), k == 5};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL invalid k=%0d got %b exp %b", k, obs, e);
      end
      if (k == 1) ratio_i = 8'd11;
      if (k == 7) ratio_i = 8'd23;
    end
  endtask

  // Alternate 23/24 per load: periods 5 and 6, mc high 3 then 0 cycles; 47 VCO cycles.
  task automatic test_back_to_back();
    logic [4:0] e;
    int vco = 0;
    int len, hi;
    do_reset();
    ratio_i = 8'd23;
    en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      len = (p % 2 == 0) ? 5 : 6;
      hi  = (p % 2 == 0) ? 3 : 0;
      for (int c = 0; c < len; c++) begin
        tick();
        if (c == 0) exp_tgl = ~exp_tgl;
        e = {c < hi, c == 0, exp_tgl, c == 0, 1'b0};
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL alt p=%0d c=%0d got %b exp %b", p, c, obs, e);
        end
        if (p < 2) vco += mc ? 5 : 4;
        if (c == 0) ratio_i = (p % 2 == 0) ? 8'd24 : 8'd23;
      end
    end
    n_tests++;
    if (vco !== 47) begin
      n_fail++;
      $display("FAIL alt_vco_sum got %0d exp %0d", vco, 47);
    end
  endtask

  // en low for 2 edges mid-period, then resume with a fresh full period.
  task automatic test_enable();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd23;
    en = 1'b1;
    tick();
    tick();
    exp_tgl = 1'b1;
    e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL en_pre got %b exp %b", obs, e);
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = {1'b0, 1'b0, exp_tgl, 1'b0, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL en_low k=%0d got %b exp %b", k, obs, e);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 5 == 0) exp_tgl = ~exp_tgl;
      e = {(k % 5) < 3, k % 5 == 0, exp_tgl, k % 5 == 0, 1'b0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL en_resume k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  // Async reset mid-period with mc=1; restart with invalid 7 -> RST_RATIO period, ratio_err.
  task automatic test_async_reset();
    logic [4:0] e;
    do_reset();
    ratio_i = 8'd23;
    en = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_rst got %b exp %b", obs, 5'b00000);
    end
    ratio_i = 8'd7;
    exp_tgl = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k % 5 == 0) exp_tgl = ~exp_tgl;
      e = {(k % 5) < 3, k % 5 == 0, exp_tgl, 1'b0, k % 5 == 0};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_rst k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady23();
    test_edge_ratios();
    test_pc_one();
    test_invalid();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
